ahb_arbiter: RTL

- Round-robin bus arbiter for the 4-master AHB interconnect.
- Sits upstream of the master-side response decoder and the master address/control mux, and drives both from its outputs.
- Issues a one-hot address-phase grant and the encoded owner ID `hmaster`, and tracks the data-phase owner so read data and responses are routed to the correct master.
- Honours locked transfers and never breaks an in-progress burst.

---
 rtl/ahb_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/ahb_arbiter.sv
// Four-master round-robin AHB arbiter: one-hot address-phase grant, encoded owner,
// lock indication and a one-hot data-phase owner, all updated on hready edges.
module ahb_arbiter (
    input  logic       hclk,
    input  logic       hreset,
    input  logic       hbusreq1,
    input  logic       hbusreq2,
    input  logic       hbusreq3,
    input  logic       hbusreq4,
    input  logic       hlock1,
    input  logic       hlock2,
    input  logic       hlock3,
    input  logic       hlock4,
    input  logic [1:0] htrans,
    input  logic       hready,
    output logic       grant1,
    output logic       grant2,
    output logic       grant3,
    output logic       grant4,
    output logic [1:0] hmaster,
    output logic       hmastlock,
    output logic       dgrant1,
    output logic       dgrant2,
    output logic       dgrant3,
    output logic       dgrant4
);

    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    logic [3:0] req_s;
    logic [3:0] lock_s;
    logic       burst_s;
    logic       hold_s;
    logic [1:0] next_owner_s;
    logic       next_lock_s;

    logic [1:0] owner_r;
    logic [3:0] grant_r;
    logic [3:0] dgrant_r;
    logic       mastlock_r;

    // First requester after the owner in rotating order; the owner itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [1:0] own, input logic [3:0] req);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        logic       hit;
        pick  = own;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx   = own + 2'(i);
            hit   = !found && req[idx];
            pick  = hit ? idx : pick;
            found = found | hit;
        end
        return pick;
    endfunction

    function automatic logic [3:0] to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    assign req_s  = {hbusreq4, hbusreq3, hbusreq2, hbusreq1};
    assign lock_s = {hlock4, hlock3, hlock2, hlock1};

    // Decide whether the owner keeps the bus, otherwise pick the next owner.
    always_comb begin
        burst_s      = (htrans == HTRANS_SEQ) || (htrans == HTRANS_BUSY);
        hold_s       = (lock_s[owner_r] && req_s[owner_r]) || burst_s || (req_s == 4'b0000);
        next_owner_s = hold_s ? owner_r : rr_pick(owner_r, req_s);
        next_lock_s  = lock_s[next_owner_s] && req_s[next_owner_s];
    end

    // Ownership registers; dgrant takes the pre-edge grant as the address phase completes.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            owner_r    <= 2'd0;
            grant_r    <= 4'b0001;
            dgrant_r   <= 4'b0001;
            mastlock_r <= 1'b0;
        end else if (hready) begin
            owner_r    <= next_owner_s;
            grant_r    <= to_onehot(next_owner_s);
            dgrant_r   <= grant_r;
            mastlock_r <= next_lock_s;
        end else begin
            owner_r    <= owner_r;
            grant_r    <= grant_r;
            dgrant_r   <= dgrant_r;
            mastlock_r <= mastlock_r;
        end
    end

    assign {grant4, grant3, grant2, grant1}     = grant_r;
    assign {dgrant4, dgrant3, dgrant2, dgrant1} = dgrant_r;
    assign hmaster   = owner_r;
    assign hmastlock = mastlock_r;

endmodule
